// File: rtl/alu_arbiter_if.sv
// ============================================================================
// Module   : alu_arbiter_if
// Purpose  : Request/response and ALU-side bus bundle for alu_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_b0;
    logic [2:0]       req_ctrl0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b1;
    logic [2:0]       req_ctrl1;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_control;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    // Requesters plus the ALU instance
    modport master (
        output req_valid, req_a0, req_b0, req_ctrl0, req_a1, req_b1, req_ctrl1,
        output rsp_ready, alu_result, alu_zero,
        input  req_ready, rsp_valid, rsp_result, rsp_zero,
        input  alu_a, alu_b, alu_control
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_ctrl0, req_a1, req_b1, req_ctrl1,
        input  rsp_ready, alu_result, alu_zero,
        output req_ready, rsp_valid, rsp_result, rsp_zero,
        output alu_a, alu_b, alu_control
    );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Round-robin sharing of one combinational ALU between two ports.
//            Optional per-port operation counters: define ALU_ARB_OPCNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_arbiter #(
    parameter int         WIDTH   = 32,
    parameter logic [0:0] RR_INIT = 1'b0
) (
    input  wire logic        clk,
    input  wire logic        reset,
`ifdef ALU_ARB_OPCNT_EN
    output logic [31:0]      op_count0,
    output logic [31:0]      op_count1,
`endif
    alu_arbiter_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_ptr;
    logic             r_owner;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_ctrl;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    logic             w_win;
    logic             w_accept;
    logic [1:0]       w_req_ready;
    logic [1:0]       w_rsp_valid;
    logic             w_rsp_done;

    always_comb begin
        w_next      = r_state;
        w_win       = r_ptr;
        w_accept    = 1'b0;
        w_req_ready = 2'b00;
        w_rsp_valid = 2'b00;
        w_rsp_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid == 2'b11)
                    w_win = r_ptr;
                else if (bus.req_valid[0])
                    w_win = 1'b0;
                else
                    w_win = 1'b1;
                // Gated by reset so nothing is offered while held in reset
                if ((bus.req_valid != 2'b00) && reset) begin
                    w_accept           = 1'b1;
                    w_req_ready[w_win] = 1'b1;
                    w_next             = S_EXEC;
                end
            end
            S_EXEC: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                w_rsp_valid[r_owner] = 1'b1;
                if (bus.rsp_ready[r_owner]) begin
                    w_rsp_done = 1'b1;
                    w_next     = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_ptr    <= RR_INIT;
            r_owner  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_ctrl   <= 3'd0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_owner <= w_win;
                r_a     <= w_win ? bus.req_a1    : bus.req_a0;
                r_b     <= w_win ? bus.req_b1    : bus.req_b0;
                r_ctrl  <= w_win ? bus.req_ctrl1 : bus.req_ctrl0;
            end
            if (r_state == S_EXEC) begin
                r_result <= bus.alu_result;
                r_zero   <= bus.alu_zero;
            end
            if (w_rsp_done)
                r_ptr <= ~r_owner;
        end
    end

`ifdef ALU_ARB_OPCNT_EN
    logic [31:0] r_cnt0;
    logic [31:0] r_cnt1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt0 <= 32'd0;
            r_cnt1 <= 32'd0;
        end else if (w_rsp_done) begin
            if (r_owner)
                r_cnt1 <= r_cnt1 + 32'd1;
            else
                r_cnt0 <= r_cnt0 + 32'd1;
        end
    end

    assign op_count0 = r_cnt0;
    assign op_count1 = r_cnt1;
`endif

    // ALU inputs come straight from the latched operands: stable until next grant
    assign bus.alu_a       = r_a;
    assign bus.alu_b       = r_b;
    assign bus.alu_control = r_ctrl;
    assign bus.req_ready   = w_req_ready;
    assign bus.rsp_valid   = w_rsp_valid;
    assign bus.rsp_result  = r_result;
    assign bus.rsp_zero    = r_zero;

endmodule

`default_nettype wire
